// File: rtl/fp_add_normalize.sv
// Two-stage FP add back end: normalize aligned sums, then round to
// nearest even and pack binary32 per lane, with per-thread rollback squash.
module fp_add_normalize #(
    parameter int LANES       = 16,
    parameter int THREAD_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wb_rollback_en,
    input  logic [THREAD_BITS-1:0] wb_rollback_thread_idx,
    input  logic                   in_valid,
    input  logic [THREAD_BITS-1:0] in_thread_idx,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*26-1:0]    in_significand,
    input  logic [LANES-1:0]       in_sticky,
    input  logic [LANES*8-1:0]     in_exponent,
    input  logic [LANES-1:0]       in_sign,
    input  logic [LANES-1:0]       in_logical_subtract,
    input  logic [LANES-1:0]       in_special,
    input  logic [LANES*32-1:0]    in_special_value,
    output logic                   out_valid,
    output logic [THREAD_BITS-1:0] out_thread_idx,
    output logic [LANES-1:0]       out_mask,
    output logic [LANES*32-1:0]    out_result
);

    typedef struct packed {
        logic [23:0] mant;
        logic        guard;
        logic        sticky;
        logic [8:0]  exp;
        logic        zero;
    } norm_t;

    function automatic norm_t f_norm(
        input logic [25:0] sig,
        input logic        stk,
        input logic [7:0]  exp
    );
        norm_t       n;
        logic [4:0]  lzc;
        logic        found;
        logic [8:0]  eff;
        logic [8:0]  sh;
        logic [24:0] shd;
        n     = '0;
        lzc   = 5'd25;
        found = 1'b0;
        for (int i = 24; i >= 0; i--) begin
            if (!found && sig[i]) begin
                lzc   = 5'(24 - i);
                found = 1'b1;
            end
        end
        eff = (exp == 8'd0) ? 9'd1 : {1'b0, exp};
        // Shift stops early so the exponent never drops below 1 (subnormal floor).
        sh  = ({4'd0, lzc} < (eff - 9'd1)) ? {4'd0, lzc} : (eff - 9'd1);
        shd = sig[24:0] << sh;
        n.zero = (sig == 26'd0) && !stk;
        if (sig[25]) begin
            n.mant   = sig[25:2];
            n.guard  = sig[1];
            n.sticky = stk | sig[0];
            n.exp    = {1'b0, exp} + 9'd1;
        end else begin
            n.mant   = shd[24:1];
            n.guard  = shd[0];
            n.sticky = stk;
            n.exp    = shd[24] ? (eff - sh) : 9'd0;
        end
        return n;
    endfunction

    function automatic logic [31:0] f_round(
        input norm_t       n,
        input logic        sign,
        input logic        lsub,
        input logic        special,
        input logic [31:0] spval
    );
        logic        rup;
        logic [24:0] m;
        logic [8:0]  e;
        rup = n.guard & (n.sticky | n.mant[0]);
        m   = {1'b0, n.mant} + {24'd0, rup};
        e   = n.exp;
        if (m[24]) begin
            m = m >> 1;
            e = e + 9'd1;
        end else if ((e == 9'd0) && m[23]) begin
            e = 9'd1;
        end
        if (special)
            return spval;
        else if (n.zero)
            return {~lsub & sign, 31'd0};
        else if (e >= 9'd255)
            return {sign, 8'hFF, 23'd0};
        else
            return {sign, e[7:0], m[22:0]};
    endfunction

    norm_t                  w_norm [LANES];
    logic [LANES*32-1:0]    w_result;
    logic                   w_a_kill;
    logic                   w_b_take;

    logic                   r_a_valid;
    logic [THREAD_BITS-1:0] r_a_thread;
    logic [LANES-1:0]       r_a_mask;
    norm_t                  r_a_norm [LANES];
    logic [LANES-1:0]       r_a_sign;
    logic [LANES-1:0]       r_a_lsub;
    logic [LANES-1:0]       r_a_special;
    logic [LANES*32-1:0]    r_a_spval;

    logic                   r_valid;
    logic [THREAD_BITS-1:0] r_thread;
    logic [LANES-1:0]       r_mask;
    logic [LANES*32-1:0]    r_result;

    always_comb begin
        for (int l = 0; l < LANES; l++)
            w_norm[l] = f_norm(in_significand[l*26 +: 26], in_sticky[l],
                               in_exponent[l*8 +: 8]);
    end

    always_comb begin
        w_result = '0;
        for (int l = 0; l < LANES; l++)
            w_result[l*32 +: 32] = f_round(r_a_norm[l], r_a_sign[l], r_a_lsub[l],
                                           r_a_special[l], r_a_spval[l*32 +: 32]);
    end

    assign w_a_kill = wb_rollback_en && (wb_rollback_thread_idx == in_thread_idx);
    assign w_b_take = r_a_valid &&
                      !(wb_rollback_en && (wb_rollback_thread_idx == r_a_thread));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_valid <= 1'b0;
            r_valid   <= 1'b0;
            r_thread  <= '0;
            r_mask    <= '0;
            r_result  <= '0;
        end else begin
            r_a_valid <= in_valid && !w_a_kill;
            r_valid   <= w_b_take;
            if (w_b_take) begin
                r_thread <= r_a_thread;
                r_mask   <= r_a_mask;
                r_result <= w_result;
            end
        end
    end

    // Stage A payload is qualified by r_a_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_a_thread  <= in_thread_idx;
            r_a_mask    <= in_mask;
            r_a_norm    <= w_norm;
            r_a_sign    <= in_sign;
            r_a_lsub    <= in_logical_subtract;
            r_a_special <= in_special;
            r_a_spval   <= in_special_value;
        end
    end

    assign out_valid      = r_valid;
    assign out_thread_idx = r_thread;
    assign out_mask       = r_mask;
    assign out_result     = r_result;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed bench for fp_add_normalize: latency, rounding, normalize,
// specials, lanes, rollback squash and mid-flight reset.
module tb_fp_add_normalize;

    localparam int LANES = 16;
    localparam int TB    = 2;

    logic                clk;
    logic                reset_n;
    logic                wb_rollback_en;
    logic [TB-1:0]       wb_rollback_thread_idx;
    logic                in_valid;
    logic [TB-1:0]       in_thread_idx;
    logic [LANES-1:0]    in_mask;
    logic [LANES*26-1:0] in_significand;
    logic [LANES-1:0]    in_sticky;
    logic [LANES*8-1:0]  in_exponent;
    logic [LANES-1:0]    in_sign;
    logic [LANES-1:0]    in_logical_subtract;
    logic [LANES-1:0]    in_special;
    logic [LANES*32-1:0] in_special_value;
    logic                out_valid;
    logic [TB-1:0]       out_thread_idx;
    logic [LANES-1:0]    out_mask;
    logic [LANES*32-1:0] out_result;

    int checks = 0;
    int errors = 0;

    fp_add_normalize #(.LANES(LANES), .THREAD_BITS(TB)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .wb_rollback_en         (wb_rollback_en),
        .wb_rollback_thread_idx (wb_rollback_thread_idx),
        .in_valid               (in_valid),
        .in_thread_idx          (in_thread_idx),
        .in_mask                (in_mask),
        .in_significand         (in_significand),
        .in_sticky              (in_sticky),
        .in_exponent            (in_exponent),
        .in_sign                (in_sign),
        .in_logical_subtract    (in_logical_subtract),
        .in_special             (in_special),
        .in_special_value       (in_special_value),
        .out_valid              (out_valid),
        .out_thread_idx         (out_thread_idx),
        .out_mask               (out_mask),
        .out_result             (out_result)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        in_valid               = 1'b0;
        in_thread_idx          = '0;
        in_mask                = '0;
        in_significand         = '0;
        in_sticky              = '0;
        in_exponent            = '0;
        in_sign                = '0;
        in_logical_subtract    = '0;
        in_special             = '0;
        in_special_value       = '0;
        wb_rollback_en         = 1'b0;
        wb_rollback_thread_idx = '0;
    endtask

    task automatic set_lane(input int l, input logic [25:0] sig, input logic [7:0] e,
                            input logic s, input logic ls, input logic st);
        in_significand[l*26 +: 26] = sig;
        in_exponent[l*8 +: 8]      = e;
        in_sign[l]                 = s;
        in_logical_subtract[l]     = ls;
        in_sticky[l]               = st;
    endtask

    // One-cycle issue; returns out_valid one and two edges later plus the result.
    task automatic pulse(input logic [TB-1:0] thr, output logic v1,
                         output logic v2, output logic [LANES*32-1:0] res);
        in_valid      = 1'b1;
        in_thread_idx = thr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        v1 = out_valid;
        @(posedge clk); #1;
        v2  = out_valid;
        res = out_result;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_result !== '0) begin errors++;
            $display("FAIL reset_result got %h want 0", out_result); end
        checks++; if (out_mask !== '0) begin errors++;
            $display("FAIL reset_mask got %h want 0", out_mask); end
        checks++; if (out_thread_idx !== '0) begin errors++;
            $display("FAIL reset_thread got %0d want 0", out_thread_idx); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_carry();
        logic v1, v2;
        logic [LANES*32-1:0] res;
        clear_inputs();
        in_mask = 16'hA5A5;
        set_lane(0, 26'h2000000, 8'd127, 1'b0, 1'b0, 1'b0);
        pulse(2'd1, v1, v2, res);
        checks++; if (v1 !== 1'b0) begin errors++;
            $display("FAIL carry_lat1 got %0b want 0", v1); end
        checks++; if (v2 !== 1'b1) begin errors++;
            $display("FAIL carry_lat2 got %0b want 1", v2); end
        checks++; if (res[31:0] !== 32'h40000000) begin errors++;
            $display("FAIL carry_result got %h want 40000000", res[31:0]); end
        checks++; if (out_thread_idx !== 2'd1) begin errors++;
            $display("FAIL carry_thread got %0d want 1", out_thread_idx); end
        checks++; if (out_mask !== 16'hA5A5) begin errors++;
            $display("FAIL carry_mask got %h want a5a5", out_mask); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL carry_drop got %0b want 0", out_valid); end
    endtask

    task automatic test_zero();
        logic v1, v2;
        logic [LANES*32-1:0] res;
        clear_inputs();
        set_lane(0, 26'h0, 8'd127, 1'b1, 1'b1, 1'b0);
        pulse(2'd0, v1, v2, res);
        checks++; if (res[31:0] !== 32'h00000000) begin errors++;
            $display("FAIL zero_sub got %h want 00000000", res[31:0]); end
        set_lane(0, 26'h0, 8'd127, 1'b1, 1'b0, 1'b0);
        pulse(2'd0, v1, v2, res);
        checks++; if (res[31:0] !== 32'h80000000) begin errors++;
            $display("FAIL zero_add got %h want 80000000", res[31:0]); end
    endtask

    task automatic test_round();
        logic v1, v2;
        logic [LANES*32-1:0] res;
        clear_inputs();
        set_lane(0, 26'h1000003, 8'd127, 1'b0, 1'b0, 1'b0);
        pulse(2'd0, v1, v2, res);
        checks++; if (res[31:0] !== 32'h3F800002) begin errors++;
            $display("FAIL round_odd_tie got %h want 3f800002", res[31:0]); end
        set_lane(0, 26'h1000001, 8'd127, 1'b0, 1'b0, 1'b0);
        pulse(2'd0, v1, v2, res);
        checks++; if (res[31:0] !== 32'h3F800000) begin errors++;
            $display("FAIL round_even_tie got %h want 3f800000", res[31:0]); end
        set_lane(0, 26'h1000001, 8'd127, 1'b0, 1'b0, 1'b1);
        pulse(2'd0, v1, v2, res);
        checks++; if (res[31:0] !== 32'h3F800001) begin errors++;
            $display("FAIL round_sticky got %h want 3f800001", res[31:0]); end
    endtask

    task automatic test_special();
        logic v1, v2;
        logic [LANES*32-1:0] res;
        clear_inputs();
        set_lane(0, 26'h3FFFFFE, 8'd254, 1'b0, 1'b0, 1'b0);
        pulse(2'd0, v1, v2, res);
        checks++; if (res[31:0] !== 32'h7F800000) begin errors++;
            $display("FAIL overflow_inf got %h want 7f800000", res[31:0]); end
        set_lane(0, 26'h2000000, 8'd127, 1'b0, 1'b0, 1'b0);
        in_special[0]          = 1'b1;
        in_special_value[31:0] = 32'h7FC00000;
        pulse(2'd0, v1, v2, res);
        checks++; if (res[31:0] !== 32'h7FC00000) begin errors++;
            $display("FAIL special_nan got %h want 7fc00000", res[31:0]); end
    endtask

    task automatic test_normalize();
        logic [25:0] sigs [7];
        logic [7:0]  exps [7];
        logic [31:0] exp_res [7];
        logic v1, v2;
        logic [LANES*32-1:0] res;
        sigs = '{26'h0400000, 26'h0000010, 26'h0400000, 26'h0400000,
                 26'h1FFFFFF, 26'h0FFFFFF, 26'h1FFFFFF};
        exps = '{8'd127, 8'd1, 8'd3, 8'd2, 8'd127, 8'd1, 8'd254};
        exp_res = '{32'h3E800000, 32'h00000008, 32'h00800000, 32'h00400000,
                    32'h40000000, 32'h00800000, 32'h7F800000};
        clear_inputs();
        for (int i = 0; i < 7; i++) begin
            set_lane(0, sigs[i], exps[i], 1'b0, 1'b0, 1'b0);
            pulse(2'd0, v1, v2, res);
            checks++; if (res[31:0] !== exp_res[i]) begin errors++;
                $display("FAIL norm_%0d got %h want %h", i, res[31:0], exp_res[i]); end
        end
    endtask

    task automatic test_lanes();
        logic v1, v2;
        logic [LANES*32-1:0] res;
        clear_inputs();
        in_mask = 16'h0080;
        set_lane(0, 26'h2000000, 8'd127, 1'b0, 1'b0, 1'b0);
        set_lane(7, 26'h1000000, 8'd127, 1'b1, 1'b0, 1'b0);
        pulse(2'd3, v1, v2, res);
        checks++; if (res[31:0] !== 32'h40000000) begin errors++;
            $display("FAIL lane0_masked got %h want 40000000", res[31:0]); end
        checks++; if (res[7*32 +: 32] !== 32'hBF800000) begin errors++;
            $display("FAIL lane7 got %h want bf800000", res[7*32 +: 32]); end
        checks++; if (out_mask !== 16'h0080) begin errors++;
            $display("FAIL lane_mask got %h want 0080", out_mask); end
    endtask

    task automatic test_rollback();
        clear_inputs();
        set_lane(0, 26'h1000000, 8'd127, 1'b0, 1'b0, 1'b0);
        in_valid      = 1'b1;
        in_thread_idx = 2'd2;
        @(posedge clk); #1;
        in_thread_idx          = 2'd1;
        wb_rollback_en         = 1'b1;
        wb_rollback_thread_idx = 2'd2;
        @(posedge clk); #1;
        in_valid       = 1'b0;
        wb_rollback_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rb_squash got %0b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++;
            $display("FAIL rb_other_valid got %0b want 1", out_valid); end
        checks++; if (out_thread_idx !== 2'd1) begin errors++;
            $display("FAIL rb_other_thread got %0d want 1", out_thread_idx); end
        in_valid               = 1'b1;
        in_thread_idx          = 2'd3;
        wb_rollback_en         = 1'b1;
        wb_rollback_thread_idx = 2'd3;
        @(posedge clk); #1;
        in_valid       = 1'b0;
        wb_rollback_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rb_same_cycle got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [4];
        want = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000};
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                set_lane(0, 26'h1000000, 8'(127 + i), 1'b0, 1'b0, 1'b0);
                in_valid      = 1'b1;
                in_thread_idx = 2'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_result[31:0] !== want[i-1] ||
                    out_thread_idx !== 2'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_%0d got v=%0b r=%h t=%0d want v=1 r=%h t=%0d",
                             i - 1, out_valid, out_result[31:0], out_thread_idx,
                             want[i-1], i - 1);
                end
            end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_end got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int seen;
        logic v1, v2;
        logic [LANES*32-1:0] res;
        clear_inputs();
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            set_lane(0, 26'h1000000, 8'(127 + i), 1'b0, 1'b0, 1'b0);
            in_valid      = 1'b1;
            in_thread_idx = 2'(i);
            if (i == 2) begin
                #1 reset_n = 1'b0;
                #1;
                checks++; if (out_valid !== 1'b0 || out_result !== '0) begin errors++;
                    $display("FAIL rst_mid_immediate got v=%0b r=%h want v=0 r=0",
                             out_valid, out_result[31:0]); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++;
            $display("FAIL rst_mid_leak got %0d outputs want 0", seen); end
        set_lane(0, 26'h2000000, 8'd127, 1'b0, 1'b0, 1'b0);
        pulse(2'd2, v1, v2, res);
        checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || res[31:0] !== 32'h40000000) begin
            errors++;
            $display("FAIL rst_recover got v1=%0b v2=%0b r=%h want 0 1 40000000",
                     v1, v2, res[31:0]); end
    endtask

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_carry();
        test_zero();
        test_round();
        test_special();
        test_normalize();
        test_lanes();
        test_rollback();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
